// File: rtl/alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin arbiter and issue/response sequencer
//            for the shared ALU; owns the architectural PSR.
//            Optional grant lock under `ALU_ARB_LOCK_EN.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [3:0]       r0_cont,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [3:0]       r1_cont,
  output logic [1:0]       gnt,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic [7:0]       rsp_psr,
  output logic [7:0]       psr_q,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_cont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [7:0]       alu_psr,
  output logic             busy
);

  localparam logic [3:0] c_OP_ADD = 4'b0101;
  localparam logic [3:0] c_OP_SUB = 4'b1001;

  logic [1:0]       w_gnt;
  logic             w_gidx;
  logic             r_last;
  logic             r_issue_v;
  logic             r_issue_own;
  logic [WIDTH-1:0] r_issue_a;
  logic [WIDTH-1:0] r_issue_b;
  logic [3:0]       r_issue_cont;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [7:0]       r_rsp_psr;
  logic [7:0]       r_psr;

  // On a tie the requester that did not win last time gets the grant.
  function automatic logic [1:0] rr_pick(input logic [1:0] rq, input logic last);
    case (rq)
      2'b01:   rr_pick = 2'b01;
      2'b10:   rr_pick = 2'b10;
      2'b11:   rr_pick = last ? 2'b01 : 2'b10;
      default: rr_pick = 2'b00;
    endcase
  endfunction

`ifdef ALU_ARB_LOCK_EN
  logic r_lock_v;
  logic r_lock_id;
  logic w_locked;

  // The lock only persists while its owner keeps lock asserted.
  assign w_locked = r_lock_v & lock[r_lock_id];

  always_comb begin
    w_gnt = 2'b00;
    if (!reset) begin
      if (w_locked) begin
        w_gnt[r_lock_id] = req[r_lock_id];
      end else begin
        w_gnt = rr_pick(req, r_last);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_v  <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (|w_gnt && lock[w_gidx]) begin
      r_lock_v  <= 1'b1;
      r_lock_id <= w_gidx;
    end else if (!w_locked) begin
      r_lock_v  <= 1'b0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;

  always_comb begin
    w_gnt = 2'b00;
    if (!reset) begin
      w_gnt = rr_pick(req, r_last);
    end
  end
`endif

  assign w_gidx = w_gnt[1];
  assign gnt    = w_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last    <= 1'b1;
      r_issue_v <= 1'b0;
    end else begin
      r_issue_v <= |w_gnt;
      if (|w_gnt) begin
        r_last <= w_gidx;
      end
    end
  end

  // Issue payload needs no reset: it is only observed while r_issue_v is set.
  always_ff @(posedge clk) begin
    if (|w_gnt) begin
      r_issue_own  <= w_gidx;
      r_issue_a    <= w_gidx ? r1_a    : r0_a;
      r_issue_b    <= w_gidx ? r1_b    : r0_b;
      r_issue_cont <= w_gidx ? r1_cont : r0_cont;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid  <= 2'b00;
      r_rsp_result <= '0;
      r_rsp_psr    <= 8'h00;
      r_psr        <= 8'h00;
    end else begin
      r_rsp_valid <= 2'b00;
      if (r_issue_v) begin
        r_rsp_valid  <= r_issue_own ? 2'b10 : 2'b01;
        r_rsp_result <= alu_result;
        r_rsp_psr    <= alu_psr;
        if (r_issue_cont == c_OP_ADD || r_issue_cont == c_OP_SUB) begin
          r_psr <= alu_psr;
        end
      end
    end
  end

  assign alu_a      = r_issue_v ? r_issue_a    : '0;
  assign alu_b      = r_issue_v ? r_issue_b    : '0;
  assign alu_cont   = r_issue_v ? r_issue_cont : 4'b0000;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_psr    = r_rsp_psr;
  assign psr_q      = r_psr;
  assign busy       = r_issue_v | (|r_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, lock;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0]  r0_cont, r1_cont;
  logic [1:0]  gnt, rsp_valid;
  logic [15:0] rsp_result, alu_a, alu_b, alu_result;
  logic [7:0]  rsp_psr, psr_q, alu_psr;
  logic [3:0]  alu_cont;
  logic        busy;

  alu_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .r0_a(r0_a), .r0_b(r0_b), .r0_cont(r0_cont),
    .r1_a(r1_a), .r1_b(r1_b), .r1_cont(r1_cont),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_psr(rsp_psr), .psr_q(psr_q),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
    .alu_result(alu_result), .alu_psr(alu_psr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // ALU behaviour: result plus flags {3'b0,Z,C,F,N,L}.
  function automatic logic [23:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] c);
    logic [16:0] s;
    logic [15:0] r;
    logic cy, f, l;
    cy = 1'b0; f = 1'b0; l = 1'b0; s = 17'd0;
    case (c)
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: r = a ^ b;
      4'b1001: begin
        s  = {1'b0, a} - {1'b0, b};
        r  = s[15:0];
        cy = s[16];
        f  = (a[15] != b[15]) && (r[15] != a[15]);
        l  = ($signed(a) < $signed(b));
      end
      default: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[15:0];
        cy = s[16];
        f  = (a[15] == b[15]) && (r[15] != a[15]);
      end
    endcase
    return {r, 3'b000, (r == 16'h0000), cy, f, r[15], l};
  endfunction

  always_comb {alu_result, alu_psr} = alu_model(alu_a, alu_b, alu_cont);

  typedef struct {
    logic [1:0]  own;
    logic [15:0] a, b;
    logic [3:0]  cont;
    logic [15:0] res;
    logic [7:0]  psr, psrq;
    int          due;
  } item_t;

  item_t iq[$];
  item_t rq[$];

  logic       m_last = 1'b1;
  logic [7:0] m_psr  = 8'h00;
  logic [1:0] m_prev_eg = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] rqv);
    if (rqv == 2'b11) return (m_last == 1'b1) ? 2'b01 : 2'b10;
    return rqv;
  endfunction

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input logic [1:0] rqv,
                      input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] c0,
                      input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] c1);
    logic [1:0] eg;
    item_t it;
    req = rqv; r0_a = a0; r0_b = b0; r0_cont = c0; r1_a = a1; r1_b = b1; r1_cont = c1;
    @(negedge clk);
    eg = exp_grant(rqv);
    chk("gnt", 64'(gnt), 64'(eg));
    if (eg != 2'b00) begin
      it.own  = eg;
      it.a    = eg[1] ? a1 : a0;
      it.b    = eg[1] ? b1 : b0;
      it.cont = eg[1] ? c1 : c0;
      {it.res, it.psr} = alu_model(it.a, it.b, it.cont);
      if (it.cont == 4'b0101 || it.cont == 4'b1001) m_psr = it.psr;
      it.psrq = m_psr;
      it.due  = cyc + 1;
      iq.push_back(it);
      it.due  = cyc + 2;
      rq.push_back(it);
      m_last = eg[1];
    end
    m_prev_eg = eg;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 16'h0, 16'h0, 4'h0, 16'h0, 16'h0, 4'h0);
  endtask

  // Holds reset for one cycle with both requesters asking, then checks cleared state.
  task automatic do_reset();
    reset = 1'b1; req = 2'b11;
    iq.delete(); rq.delete();
    m_last = 1'b1; m_psr = 8'h00; m_prev_eg = 2'b00;
    @(negedge clk);
    chk("gnt_in_reset", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    chk("rst_psr_q", 64'(psr_q), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'({rsp_result, rsp_psr}), 64'd0);
    chk("rst_alu_idle", 64'({alu_a, alu_b, alu_cont}), 64'd0);
    reset = 1'b0; req = 2'b00;
  endtask

  // Monitor: pops the scoreboard whenever an issue or response is due.
  always @(negedge clk) begin : monitor
    logic ei, er;
    if (!reset) begin
      ei = (iq.size() > 0) && (iq[0].due == cyc);
      er = (rq.size() > 0) && (rq[0].due == cyc);
      if (ei) begin
        chk("alu_issue", 64'({alu_a, alu_b, alu_cont}), 64'({iq[0].a, iq[0].b, iq[0].cont}));
        void'(iq.pop_front());
      end else begin
        chk("alu_idle", 64'({alu_a, alu_b, alu_cont}), 64'd0);
      end
      if (er) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(rq[0].own));
        chk("rsp_result", 64'(rsp_result), 64'(rq[0].res));
        chk("rsp_psr", 64'(rsp_psr), 64'(rq[0].psr));
        chk("psr_q", 64'(psr_q), 64'(rq[0].psrq));
        void'(rq.pop_front());
      end else begin
        chk("rsp_quiet", 64'(rsp_valid), 64'd0);
      end
      chk("busy", 64'(busy), 64'(ei | er));
    end
  end

  function automatic logic [3:0] rand_op();
    logic [3:0] v;
    v = 4'($urandom);
    case ($urandom_range(0, 5))
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0011;
      3: return 4'b0101;
      4: return 4'b1001;
      default: return v;
    endcase
  endfunction

  initial begin
    logic [1:0]  nr;
    logic [15:0] na0, nb0, na1, nb1;
    logic [3:0]  nc0, nc1;
    reset = 1'b1; req = 2'b00; lock = 2'b00;
    r0_a = '0; r0_b = '0; r0_cont = '0; r1_a = '0; r1_b = '0; r1_cont = '0;
    @(posedge clk); #1;
    do_reset();
    do_reset();

    // Single ADD from requester 0
    step(2'b01, 16'h7FFF, 16'h0001, 4'b0101, 16'h0, 16'h0, 4'h0);
    idle(3);
    chk("add_result", 64'(rsp_result), 64'h8000);
    chk("add_psr", 64'(rsp_psr), 64'h06);
    chk("add_psr_q", 64'(psr_q), 64'h06);

    // SUB from requester 1
    step(2'b10, 16'h0, 16'h0, 4'h0, 16'h0003, 16'h0005, 4'b1001);
    idle(3);
    chk("sub_result", 64'(rsp_result), 64'hFFFE);
    chk("sub_psr_q", 64'(psr_q), 64'h0B);

    // ADD then AND back to back: AND must not touch psr_q
    step(2'b01, 16'h7FFF, 16'h0001, 4'b0101, 16'h0, 16'h0, 4'h0);
    step(2'b01, 16'h00F0, 16'h0FFF, 4'b0001, 16'h0, 16'h0, 4'h0);
    idle(3);
    chk("and_result", 64'(rsp_result), 64'h00F0);
    chk("and_psr_q", 64'(psr_q), 64'h06);

    // Continuous contention straight after reset
    do_reset();
    for (int k = 0; k < 4; k++)
      step(2'b11, 16'h8000, 16'h8000, 4'b0101, 16'h0003, 16'h0005, 4'b1001);
    idle(3);
    chk("contend_psr_q", 64'(psr_q), 64'h0B);

    // Reset in the cycle after a grant drops the op
    step(2'b01, 16'h1234, 16'h0001, 4'b0101, 16'h0, 16'h0, 4'h0);
    do_reset();
    idle(3);

    // Randomized traffic; lock is toggled to show it has no effect
    for (int k = 0; k < 600; k++) begin
      nr = req; na0 = r0_a; nb0 = r0_b; nc0 = r0_cont; na1 = r1_a; nb1 = r1_b; nc1 = r1_cont;
      if (!(req[0] && !m_prev_eg[0])) begin
        nr[0] = 1'($urandom_range(0, 1));
        na0 = 16'($urandom); nb0 = 16'($urandom); nc0 = rand_op();
      end
      if (!(req[1] && !m_prev_eg[1])) begin
        nr[1] = 1'($urandom_range(0, 1));
        na1 = 16'($urandom); nb1 = 16'($urandom); nc1 = rand_op();
      end
      lock = 2'($urandom);
      step(nr, na0, nb0, nc0, na1, nb1, nc1);
    end
    lock = 2'b00;
    idle(4);
    chk("scoreboard_drained", 64'(iq.size() + rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
